wb_pic186: RTL and testbench
============================

Name: wb_pic186

Overview:
- Parametrised 80186-style programmable interrupt controller for the Zet coprocessor SoC.
- Replaces simple_pic, the ad-hoc tube interrupt edge synchroniser and the ack-only interrupt-control stub slave at I/O 0xFF20-0xFF3E.
- Provides up to 8 maskable sources, each with per-channel edge/level mode and a 3-bit priority.
- Adds in-service nesting, EOI handling and vector delivery to the Zet INTA cycle.

Parameters:
- NUM_IRQ, 4: number of interrupt sources, 1..8.
- VEC_BASE, 8'h0C: vector of channel 0; channel i returns VEC_BASE+i.
- SPUR_VEC, 8'h07: vector returned when INTA finds no eligible request.
- SYNC_STAGES, 2: flip-flop synchroniser depth on irq_i, 2..4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wb_adr_i  in  4  word index within 0xFF20-0xFF3E (address bits [4:1])
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_sel_i  in  2  byte selects
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  acknowledge
- irq_i  in  NUM_IRQ  asynchronous interrupt sources
- intr_o  out  1  interrupt request to Zet (wb_tgc_i)
- inta_i  in  1  interrupt acknowledge from Zet (wb_tgc_o)
- vec_o  out  8  vector placed on the data bus during INTA

Behaviour:
- Reset (async, rst=1):
  - outputs: wb_ack_o=0, wb_dat_o=0, intr_o=0, vec_o=SPUR_VEC.
  - MASK=all ones; INSERV=0; REQ=0; synchronisers=0.
  - CTRL[i]: LTM=0, PRI=7.
- Register map, by word index:
  - 1 EOI, write-only:
    - bit15=1: non-specific EOI; clear the in-service bit with the best (lowest value) priority; ties go to the lowest index.
    - bit15=0: specific EOI; clear INSERV[bits2:0].
    - Applied on any write with sel≠0.
  - 4 MASK, R/W, bits[NUM_IRQ-1:0]; 1=masked.
  - 6 INSERV, read-only.
  - 7 REQST, read; write-1-to-clear for edge-mode channels.
  - 8+i CTRL channel i:
    - bit4 LTM (1=level, 0=rising edge); bits2:0 PRI.
    - Indices ≥8+NUM_IRQ read 0 and ignore writes.
  - All other indices read 0 and ignore writes.
  - Writes honour sel: sel[0] covers bits7:0, sel[1] covers bits15:8.
- Wishbone handshake:
  - wb_ack_o pulses 1 cycle, registered, one clock after cyc&stb while ack=0, giving 1 wait state per access.
  - wb_dat_o is valid while ack=1 and 0 otherwise.
  - Register side effects commit on the ack cycle.
- Input path:
  - Each irq_i passes through SYNC_STAGES flops.
  - Edge mode: a 0→1 transition of the synchronised level sets REQ[i].
  - Level mode: REQ[i] equals the synchronised level.
- Arbitration:
  - Eligible = REQ & ~MASK & (PRI strictly better than the best in-service PRI, or INSERV=0).
  - Winner = lowest PRI, ties to lowest index.
  - intr_o is registered: 1 the cycle after any eligible request exists, 0 otherwise.
- INTA sequence:
  - On the rising edge of inta_i (registered detect), in one cycle:
    - latch vec_o = VEC_BASE+winner;
    - set INSERV[winner];
    - clear REQ[winner] if the channel is in edge mode.
  - If there is no winner at that edge, vec_o=SPUR_VEC and there are no state changes.
  - vec_o holds until the next INTA.
  - intr_o drops the following cycle unless another channel is still eligible.
- Simultaneous events:
  - An edge set and a REQST write-1-clear in the same cycle: the set wins.
  - EOI and INTA in the same cycle: EOI acts on the pre-cycle INSERV, then the new INSERV bit is set.
  - A MASK write takes effect on intr_o the next cycle.
  - inta_i held high across multiple cycles acknowledges once.

Optional Feature:
- Macro: PIC186_POLL_EN.
- Defined:
  - Word index 2 (POLL) reads bit15=eligible-pending and bits2:0=winner.
  - A read with bit15=1 performs the INTA side effects (sets INSERV and clears the edge REQ) on the ack cycle, without changing vec_o.
  - Word index 3 (POLLSTS) returns the same value without side effects.
- Undefined: indices 2 and 3 read 0 and have no side effects.

Decomposition:
- Shared package pic186_pkg:
  - register index constants (EOI=1, MASK=4, INSERV=6, REQST=7, CTRL0=8);
  - CTRL field positions (LTM=4, PRI=2:0);
  - CTRL reset value 16'h0007;
  - EOI non-specific bit 15.
- One combinational sub-module, pic186_prio_enc: takes REQ, MASK, INSERV and the PRI vector; outputs winner index, valid, and best-in-service index.

Test Plan:
- Reset, then read MASK, CTRL0 and INSERV → 0x000F, 0x0007, 0x0000 (NUM_IRQ=4).
- Unmask ch0 (MASK=0x000E); pulse irq_i[0] for 1 cycle → intr_o=1 within SYNC_STAGES+3 cycles. Raise inta_i → vec_o=0x0C, INSERV=0x0001, intr_o=0 next cycle.
- CTRL1.PRI=1, CTRL2.PRI=1, unmask all, fire ch1 and ch2 together → first INTA gives 0x0D; INSERV=0x0002 blocks ch2. Write EOI 0x8000 → INSERV=0; second INTA gives 0x0E.
- Level mode on ch3: hold irq_i[3]=1, INTA → 0x0F. Drop irq_i[3] before a second INTA → SPUR_VEC 0x07, INSERV unchanged.
- Write REQST=0x0001 on the same cycle as a ch0 edge → REQST bit0 reads 1. Then write 1 with no edge → reads 0.
- PIC186_POLL_EN: ch0 pending, read index 2 → 0x8000 and INSERV=0x0001. Read again → 0x0000.

Source files
------------

// File: rtl/pic186_pkg.sv
// Shared register map, CTRL field layout and reset constants for the wb_pic186 interrupt controller.
package pic186_pkg;

  localparam logic [3:0] IDX_EOI     = 4'd1;
  localparam logic [3:0] IDX_POLL    = 4'd2;
  localparam logic [3:0] IDX_POLLSTS = 4'd3;
  localparam logic [3:0] IDX_MASK    = 4'd4;
  localparam logic [3:0] IDX_INSERV  = 4'd6;
  localparam logic [3:0] IDX_REQST   = 4'd7;
  localparam logic [3:0] IDX_CTRL0   = 4'd8;

  localparam int CTRL_LTM_BIT  = 4;
  localparam int CTRL_PRI_LSB  = 0;
  localparam int EOI_NSPEC_BIT = 15;

  localparam logic [15:0] CTRL_RST = 16'h0007;

  typedef struct packed {
    logic       ltm;
    logic [2:0] pri;
  } ctrl_t;

  function automatic ctrl_t ctrl_unpack(input logic [15:0] d);
    ctrl_t c;
    c.ltm = d[CTRL_LTM_BIT];
    c.pri = d[CTRL_PRI_LSB +: 3];
    return c;
  endfunction

  function automatic logic [15:0] ctrl_pack(input ctrl_t c);
    logic [15:0] d;
    d = '0;
    d[CTRL_LTM_BIT]      = c.ltm;
    d[CTRL_PRI_LSB +: 3] = c.pri;
    return d;
  endfunction

endpackage

// File: rtl/pic186_prio_enc.sv
// Combinational arbiter: best in-service channel, then the best eligible request that may nest above it.
// Lower PRI value wins; ties resolve to the lowest channel index.
module pic186_prio_enc #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]   req_i,
  input  logic [NUM_IRQ-1:0]   mask_i,
  input  logic [NUM_IRQ-1:0]   inserv_i,
  input  logic [3*NUM_IRQ-1:0] pri_i,
  output logic [2:0]           win_idx_o,
  output logic                 win_vld_o,
  output logic [2:0]           is_idx_o,
  output logic                 is_vld_o
);

  logic [2:0] is_pri;
  logic [2:0] win_pri;

  always_comb begin
    is_vld_o = 1'b0;
    is_idx_o = '0;
    is_pri   = 3'd7;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (inserv_i[i] && (!is_vld_o || pri_i[3*i +: 3] < is_pri)) begin
        is_vld_o = 1'b1;
        is_idx_o = 3'(i);
        is_pri   = pri_i[3*i +: 3];
      end
    end
  end

  always_comb begin
    win_vld_o = 1'b0;
    win_idx_o = '0;
    win_pri   = 3'd7;
    for (int i = 0; i < NUM_IRQ; i++) begin
      // A request may only nest when strictly more urgent than what is already being serviced.
      if (req_i[i] && !mask_i[i] && (!is_vld_o || pri_i[3*i +: 3] < is_pri) &&
          (!win_vld_o || pri_i[3*i +: 3] < win_pri)) begin
        win_vld_o = 1'b1;
        win_idx_o = 3'(i);
        win_pri   = pri_i[3*i +: 3];
      end
    end
  end

endmodule

// File: rtl/wb_pic186.sv
// 80186-style PIC on a Wishbone slave port: synchronised edge/level sources, nesting by priority, EOI and INTA vectoring.
// Optional POLL/POLLSTS registers at word indices 2/3 are built when PIC186_POLL_EN is defined.
module wb_pic186
  import pic186_pkg::*;
#(
  parameter int         NUM_IRQ     = 4,
  parameter logic [7:0] VEC_BASE    = 8'h0C,
  parameter logic [7:0] SPUR_VEC    = 8'h07,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         wb_adr_i,
  input  logic [15:0]        wb_dat_i,
  output logic [15:0]        wb_dat_o,
  input  logic [1:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic               wb_ack_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               intr_o,
  input  logic               inta_i,
  output logic [7:0]         vec_o
);

  logic               ack_q, ack_d;
  logic               intr_q, intr_d;
  logic               inta_q, inta_d;
  logic [7:0]         vec_q, vec_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] inserv_q, inserv_d;
  logic [NUM_IRQ-1:0] req_q, req_d;
  logic [NUM_IRQ-1:0] lvl_prev_q, lvl_prev_d;
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
  ctrl_t              ctrl_q [NUM_IRQ];
  ctrl_t              ctrl_d [NUM_IRQ];

  logic [NUM_IRQ-1:0]   lvl, rise, req_eff, win_oh;
  logic [3*NUM_IRQ-1:0] pri_vec;
  logic [2:0]           win_idx, is_idx;
  logic                 win_vld, is_vld;
  logic                 wr, rd, inta_rise, poll_take, take;
  logic [15:0]          rdata;

  always_comb begin
    lvl  = sync_q[SYNC_STAGES-1];
    rise = lvl & ~lvl_prev_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      req_eff[i]         = ctrl_q[i].ltm ? lvl[i] : req_q[i];
      pri_vec[3*i +: 3]  = ctrl_q[i].pri;
    end
    wr        = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;
    rd        = ack_q & wb_cyc_i & wb_stb_i & ~wb_we_i;
    inta_rise = inta_i & ~inta_q;
  end

  pic186_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req_i     (req_eff),
    .mask_i    (mask_q),
    .inserv_i  (inserv_q),
    .pri_i     (pri_vec),
    .win_idx_o (win_idx),
    .win_vld_o (win_vld),
    .is_idx_o  (is_idx),
    .is_vld_o  (is_vld)
  );

`ifdef PIC186_POLL_EN
  assign poll_take = rd && (wb_adr_i == IDX_POLL) && win_vld;
`else
  assign poll_take = 1'b0;
`endif

  always_comb begin
    take  = (inta_rise || poll_take) && win_vld;
    ack_d = wb_cyc_i & wb_stb_i & ~ack_q;
    inta_d = inta_i;
    intr_d = win_vld;
    lvl_prev_d = lvl;
    sync_d[0] = irq_i;
    for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];

    vec_d = vec_q;
    if (inta_rise) vec_d = win_vld ? VEC_BASE + {5'b0, win_idx} : SPUR_VEC;

    mask_d = mask_q;
    if (wr && wb_adr_i == IDX_MASK && wb_sel_i[0]) mask_d = wb_dat_i[NUM_IRQ-1:0];

    inserv_d = inserv_q;
    req_d    = req_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      win_oh[i] = take && (win_idx == 3'(i));
      ctrl_d[i] = ctrl_q[i];
      if (wr && wb_adr_i == 4'(IDX_CTRL0 + i) && wb_sel_i[0]) ctrl_d[i] = ctrl_unpack(wb_dat_i);

      // EOI sees the pre-cycle INSERV; a same-cycle acknowledge is OR-ed in afterwards.
      if (wr && wb_adr_i == IDX_EOI && wb_sel_i != 2'b00) begin
        if (wb_dat_i[EOI_NSPEC_BIT]) begin
          if (is_vld && is_idx == 3'(i)) inserv_d[i] = 1'b0;
        end else if (wb_dat_i[2:0] == 3'(i)) begin
          inserv_d[i] = 1'b0;
        end
      end
      if (win_oh[i]) inserv_d[i] = 1'b1;

      if (ctrl_q[i].ltm) begin
        req_d[i] = 1'b0;
      end else begin
        if (wr && wb_adr_i == IDX_REQST && wb_sel_i[0] && wb_dat_i[i]) req_d[i] = 1'b0;
        if (win_oh[i]) req_d[i] = 1'b0;
        if (rise[i])   req_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
`ifdef PIC186_POLL_EN
      IDX_POLL, IDX_POLLSTS: rdata = {win_vld, 12'b0, win_idx};
`endif
      IDX_MASK:   rdata[NUM_IRQ-1:0] = mask_q;
      IDX_INSERV: rdata[NUM_IRQ-1:0] = inserv_q;
      IDX_REQST:  rdata[NUM_IRQ-1:0] = req_eff;
      default: begin
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (wb_adr_i == 4'(IDX_CTRL0 + i)) rdata = ctrl_pack(ctrl_q[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q      <= 1'b0;
      intr_q     <= 1'b0;
      inta_q     <= 1'b0;
      vec_q      <= SPUR_VEC;
      mask_q     <= '1;
      inserv_q   <= '0;
      req_q      <= '0;
      lvl_prev_q <= '0;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      for (int i = 0; i < NUM_IRQ; i++) ctrl_q[i] <= ctrl_unpack(CTRL_RST);
    end else begin
      ack_q      <= ack_d;
      intr_q     <= intr_d;
      inta_q     <= inta_d;
      vec_q      <= vec_d;
      mask_q     <= mask_d;
      inserv_q   <= inserv_d;
      req_q      <= req_d;
      lvl_prev_q <= lvl_prev_d;
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < NUM_IRQ; i++) ctrl_q[i] <= ctrl_d[i];
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = ack_q ? rdata : 16'h0000;
  assign intr_o   = intr_q;
  assign vec_o    = vec_q;

endmodule

// File: tb/tb_wb_pic186.sv
// Bench for wb_pic186: directed scenarios, then random register/IRQ/INTA traffic against a behavioural model.
module tb_wb_pic186;
  localparam int         N  = 4;
  localparam int         SS = 2;
  localparam logic [7:0] VB = 8'h0C;
  localparam logic [7:0] SV = 8'h07;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   wb_adr_i;
  logic [15:0]  wb_dat_i, wb_dat_o;
  logic [1:0]   wb_sel_i;
  logic         wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
  logic [N-1:0] irq_i;
  logic         intr_o, inta_i;
  logic [7:0]   vec_o;

  wb_pic186 #(.NUM_IRQ(N), .VEC_BASE(VB), .SPUR_VEC(SV), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .irq_i(irq_i), .intr_o(intr_o), .inta_i(inta_i), .vec_o(vec_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  task automatic wb_bus(input logic we, input logic [3:0] adr, input logic [15:0] wd,
                        input logic [1:0] sel, output logic [15:0] rdat);
    int t;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = wd;   wb_sel_i = sel;
    rdat = '0;
    t = 0;
    @(negedge clk);
    while (!wb_ack_o && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!wb_ack_o) chk("ack_timeout", 16'd0, 16'd1);
    else rdat = wb_dat_o;
    @(posedge clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [3:0] adr, input logic [15:0] wd, input logic [1:0] sel = 2'b11);
    logic [15:0] dummy;
    wb_bus(1'b1, adr, wd, sel, dummy);
  endtask

  task automatic wb_rd(input logic [3:0] adr, output logic [15:0] rdat);
    wb_bus(1'b0, adr, 16'h0000, 2'b11, rdat);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] adr, input logic [15:0] exp);
    logic [15:0] v;
    wb_rd(adr, v);
    chk(tag, v, exp);
  endtask

  task automatic do_inta(input int hold, output logic [7:0] v);
    @(negedge clk);
    inta_i = 1'b1;
    @(negedge clk);
    v = vec_o;
    repeat (hold - 1) @(negedge clk);
    inta_i = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model state
  logic [N-1:0] m_mask, m_inserv, m_edge, m_lvl, m_ltm;
  logic [2:0]   m_pri [N];

  task automatic m_reset();
    m_mask = '1; m_inserv = '0; m_edge = '0; m_lvl = '0; m_ltm = '0;
    for (int i = 0; i < N; i++) m_pri[i] = 3'd7;
  endtask

  function automatic int m_best_is();
    int b = -1;
    for (int i = 0; i < N; i++)
      if (m_inserv[i] && (b < 0 || m_pri[i] < m_pri[b])) b = i;
    return b;
  endfunction

  function automatic logic [N-1:0] m_reqst();
    return (m_ltm & m_lvl) | (~m_ltm & m_edge);
  endfunction

  function automatic int m_winner();
    int lim = 8;
    int w = -1;
    int b = m_best_is();
    logic [N-1:0] r = m_reqst();
    if (b >= 0) lim = int'(m_pri[b]);
    for (int i = 0; i < N; i++)
      if (r[i] && !m_mask[i] && int'(m_pri[i]) < lim && (w < 0 || m_pri[i] < m_pri[w])) w = i;
    return w;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  v;
    logic [15:0] d, rv;
    logic [1:0]  s;
    int          w, ch, op, hold, idx, b;

    rst = 1'b1; inta_i = 1'b0; irq_i = '0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    settle(3);
    chk("rst_intr", {15'b0, intr_o}, 16'h0000);
    chk("rst_vec",  {8'b0, vec_o},   {8'b0, SV});
    chk("rst_ack",  {15'b0, wb_ack_o}, 16'h0000);
    chk("rst_dat",  wb_dat_o, 16'h0000);
    rst = 1'b0;
    settle(2);
    rd_chk("rst_mask",   4'd4, 16'h000F);
    rd_chk("rst_ctrl0",  4'd8, 16'h0007);
    rd_chk("rst_inserv", 4'd6, 16'h0000);
    @(negedge clk);
    chk("ack_single", {15'b0, wb_ack_o}, 16'h0000);
    rd_chk("unmapped_idx0",  4'd0,  16'h0000);
    rd_chk("unmapped_ctrl4", 4'd12, 16'h0000);

    // Single edge on ch0
    wb_wr(4'd4, 16'h000E);
    @(negedge clk); irq_i[0] = 1'b1;
    @(negedge clk); irq_i[0] = 1'b0;
    w = 0;
    for (int k = 0; k < SS + 3 && !intr_o; k++) begin
      @(negedge clk);
      w = k;
    end
    chk("ch0_intr", {15'b0, intr_o}, 16'h0001);
    do_inta(1, v);
    chk("ch0_vec", {8'b0, v}, 16'h000C);
    @(negedge clk);
    chk("ch0_intr_drop", {15'b0, intr_o}, 16'h0000);
    rd_chk("ch0_inserv", 4'd6, 16'h0001);
    wb_wr(4'd1, 16'h0000);

    // Equal-priority tie and nesting block
    wb_wr(4'd9, 16'h0001);
    wb_wr(4'd10, 16'h0001);
    wb_wr(4'd4, 16'h0000);
    @(negedge clk); irq_i = 4'b0110;
    @(negedge clk); irq_i = 4'b0000;
    settle(8);
    chk("tie_intr", {15'b0, intr_o}, 16'h0001);
    do_inta(1, v);
    chk("tie_vec1", {8'b0, v}, 16'h000D);
    settle(2);
    chk("tie_blocked", {15'b0, intr_o}, 16'h0000);
    rd_chk("tie_inserv", 4'd6, 16'h0002);
    wb_wr(4'd1, 16'h8000);
    rd_chk("nseoi_inserv", 4'd6, 16'h0000);
    settle(3);
    chk("tie_intr2", {15'b0, intr_o}, 16'h0001);
    do_inta(1, v);
    chk("tie_vec2", {8'b0, v}, 16'h000E);
    wb_wr(4'd1, 16'h8000);

    // Level mode on ch3
    wb_wr(4'd11, 16'h0010);
    rd_chk("ctrl3_rb", 4'd11, 16'h0010);
    @(negedge clk); irq_i[3] = 1'b1;
    settle(8);
    do_inta(1, v);
    chk("lvl_vec", {8'b0, v}, 16'h000F);
    rd_chk("lvl_inserv", 4'd6, 16'h0008);
    @(negedge clk); irq_i[3] = 1'b0;
    settle(8);
    do_inta(1, v);
    chk("spur_vec", {8'b0, v}, {8'b0, SV});
    rd_chk("spur_inserv", 4'd6, 16'h0008);
    wb_wr(4'd1, 16'h0003);
    rd_chk("seoi_inserv", 4'd6, 16'h0000);

    // Edge set and REQST clear in the same cycle
    @(negedge clk); irq_i[0] = 1'b1;
    wb_wr(4'd7, 16'h0001, 2'b01);
    rd_chk("reqst_setwins", 4'd7, 16'h0001);
    wb_wr(4'd7, 16'h0001, 2'b01);
    rd_chk("reqst_w1c", 4'd7, 16'h0000);
    @(negedge clk); irq_i[0] = 1'b0;
    settle(4);

    // Poll registers
    @(negedge clk); irq_i[0] = 1'b1;
    @(negedge clk); irq_i[0] = 1'b0;
    settle(8);
`ifdef PIC186_POLL_EN
    rd_chk("pollsts", 4'd3, 16'h8000);
    rd_chk("pollsts_nose", 4'd6, 16'h0000);
    rd_chk("poll1", 4'd2, 16'h8000);
    rd_chk("poll_inserv", 4'd6, 16'h0001);
    rd_chk("poll2", 4'd2, 16'h0000);
    chk("poll_vec", {8'b0, vec_o}, {8'b0, SV});
`else
    rd_chk("poll_off", 4'd2, 16'h0000);
    rd_chk("pollsts_off", 4'd3, 16'h0000);
    rd_chk("poll_off_inserv", 4'd6, 16'h0000);
    rd_chk("poll_off_reqst", 4'd7, 16'h0001);
`endif

    // Random traffic against the model
    @(negedge clk); rst = 1'b1; irq_i = '0;
    settle(2);
    rst = 1'b0;
    m_reset();
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 5);
      s  = 2'($urandom_range(1, 3));
      d  = 16'($urandom);
      case (op)
        0: begin
          d[3:0] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
          wb_wr(4'd4, d, s);
          if (s[0]) m_mask = d[N-1:0];
        end
        1: begin
          ch = $urandom_range(0, N - 1);
          wb_wr(4'(8 + ch), d, s);
          if (s[0]) begin
            m_ltm[ch] = d[4];
            m_pri[ch] = d[2:0];
            if (d[4]) m_edge[ch] = 1'b0;
          end
        end
        2: begin
          d[N-1:0] = N'($urandom);
          @(negedge clk); irq_i = d[N-1:0];
          for (int i = 0; i < N; i++)
            if (!m_ltm[i] && d[i] && !m_lvl[i]) m_edge[i] = 1'b1;
          m_lvl = d[N-1:0];
        end
        3: begin
          hold = $urandom_range(1, 3);
          w = m_winner();
          do_inta(hold, v);
          chk("rnd_vec", {8'b0, v}, (w < 0) ? {8'b0, SV} : {8'b0, VB + 8'(w)});
          if (w >= 0) begin
            m_inserv[w] = 1'b1;
            if (!m_ltm[w]) m_edge[w] = 1'b0;
          end
        end
        4: begin
          if ($urandom_range(0, 1) == 1) begin
            d[15] = 1'b1;
            wb_wr(4'd1, d, s);
            b = m_best_is();
            if (b >= 0) m_inserv[b] = 1'b0;
          end else begin
            idx = $urandom_range(0, 7);
            d = 16'(idx);
            wb_wr(4'd1, d, s);
            if (idx < N) m_inserv[idx] = 1'b0;
          end
        end
        default: begin
          d[N-1:0] = N'($urandom);
          wb_wr(4'd7, d, 2'b01);
          m_edge = m_edge & ~(d[N-1:0] & ~m_ltm);
        end
      endcase
      settle(6);
      chk("rnd_intr", {15'b0, intr_o}, {15'b0, m_winner() >= 0});
      case ($urandom_range(0, 3))
        0: rd_chk("rnd_mask", 4'd4, {12'b0, m_mask});
        1: rd_chk("rnd_inserv", 4'd6, {12'b0, m_inserv});
        2: rd_chk("rnd_reqst", 4'd7, {12'b0, m_reqst()});
        default: begin
          ch = $urandom_range(0, N - 1);
          wb_rd(4'(8 + ch), rv);
          chk("rnd_ctrl", rv, {11'b0, m_ltm[ch], 1'b0, m_pri[ch]});
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
